fifo_disp_feeder: RTL and testbench
===================================

// Module: fifo_disp_feeder
// PURPOSE
//  Upstream feeder for the dual-page seven-segment selector. Snapshots async-FIFO status, converts occupancy and free count to BCD.
//  Drives two 6-nibble pages: A = write view, B = read view. Generates the page-select bit from a debounced key.
// PARAMETERS
//  ADDR_W          4           FIFO address width; DEPTH = 2**ADDR_W; legal range 1..9 (DEPTH <= 512)
//  DEB_CYCLES      500_000     cycles key_n must be stable before a level is accepted
//  REFRESH_CYCLES  5_000_000   snapshot/convert period in cycles; must be > ADDR_W+4
//  PAGE_TICKS      100_000_000 auto page-flip period (used only with FIFO_DISP_AUTO_PAGE_EN)
// PORTS
//  clk                  in   1         system clock
//  rst_n                in   1         synchronous reset, active-low
//  key_n                in   1         raw page key, active-low, asynchronous to clk
//  wr_data              in   8         last word written to the FIFO
//  rd_data              in   8         last word read from the FIFO
//  wr_ptr               in   ADDR_W+1  binary write pointer, already synchronised into clk domain
//  rd_ptr               in   ADDR_W+1  binary read pointer, already synchronised into clk domain
//  full                 in   1         FIFO full flag
//  empty                in   1         FIFO empty flag
//  select               out  1         0 = page A shown, 1 = page B shown
//  HEX5a,HEX4a          out  4 each    wr_data snapshot: high nibble, low nibble
//  HEX3a,HEX3b          out  4 each    flag nibble {2'b00, full, empty}
//  HEX2a,HEX1a,HEX0a    out  4 each    occupancy in BCD: hundreds, tens, ones
//  HEX5b,HEX4b          out  4 each    rd_data snapshot: high nibble, low nibble
//  HEX2b,HEX1b,HEX0b    out  4 each    free slots (DEPTH-occ) in BCD: hundreds, tens, ones
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - all HEX outputs = 0; select = 0; all counters = 0.
//   - debounced key level = 1; in-flight conversion aborted.
//  Key input path:
//   - key_n passes through a 2-flop synchroniser.
//   - The debounce counter clears on any change of the synchronised level.
//   - The accepted level updates after DEB_CYCLES stable cycles.
//   - An accepted 1->0 transition toggles select exactly once; holding the key gives no repeat.
//  Refresh counter: wraps at REFRESH_CYCLES-1 and issues a 1-cycle tick.
//  FSM IDLE -> CONV -> LOAD -> IDLE.
//   - IDLE: on tick, capture wr_data, rd_data, full, empty and occ.
//   - occ = (wr_ptr - rd_ptr) mod 2**(ADDR_W+1), saturated to DEPTH.
//   - free = DEPTH - occ. Go to CONV.
//   - CONV: two bin2bcd_seq instances run shift-add-3 in parallel, ADDR_W+1 cycles.
//   - LOAD: all page A/B nibbles update together in one cycle, so no partial display. Return to IDLE.
//   - Latency: tick-to-output = ADDR_W+3 cycles.
//   - A tick arriving outside IDLE is dropped.
//  Outputs hold their values between LOADs. select never changes the page contents.
// CONFIGURATION
//  FIFO_DISP_AUTO_PAGE_EN defined:
//   - a PAGE_TICKS counter toggles select on wrap.
//   - The counter restarts on any key toggle.
//   - A key toggle and an auto toggle in the same cycle give a single toggle.
//  Not defined: select changes only via the key; no page counter is built.
// STRUCTURE
//  fifo_disp_pkg:
//   - nibble_t (logic [3:0]) and bcd3_t (3 x nibble_t)
//   - fsm_t {IDLE, CONV, LOAD}
//   - function flag_nib(full, empty)
//  Sub-module bin2bcd_seq #(W): start/bin in; busy/done/bcd3_t out. Instantiated twice (occ, free).
// TESTING (ADDR_W=4, DEB_CYCLES=4, REFRESH_CYCLES=16, PAGE_TICKS=64)
//  1. wr_ptr=5'd13, rd_ptr=5'd2, wr_data=8'hA7, full=0, empty=0, after tick+7 cycles ->
//     HEX5a..HEX0a = A,7,0,0,1,1; HEX2b..HEX0b = 0,0,5.
//  2. wr_ptr=5'd3, rd_ptr=5'd19 (wrap, occ=16), full=1 -> HEX3a=4'h2, occ BCD=0,1,6, free BCD=0,0,0.
//  3. key_n glitch low for 3 cycles -> select unchanged.
//     key_n low 10 cycles -> select toggles once, then stays.
//  4. Illegal wr_ptr=5'd30, rd_ptr=5'd0 -> occ saturates to 16 (0,1,6).
//  5. rst_n=0 two cycles after a tick (mid-CONV) -> all HEX=0 and select=0 next edge.
//     After release, the first valid update comes 16+7 cycles later.
//  6. FIFO_DISP_AUTO_PAGE_EN: no key activity -> select toggles every 64 cycles.
//     Key accept on the auto-wrap cycle -> exactly one toggle.

Source files
------------

// File: rtl/fifo_disp_pkg.sv
// Shared types and helpers for the FIFO status display feeder.
package fifo_disp_pkg;

  typedef logic [3:0] nibble_t;
  // Index 2 = hundreds, 1 = tens, 0 = ones.
  typedef nibble_t [2:0] bcd3_t;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} fsm_t;

  function automatic nibble_t flag_nib(input logic full, input logic empty);
    return {2'b00, full, empty};
  endfunction

endpackage

// File: rtl/fifo_disp_bin2bcd_seq.sv
// Sequential shift-add-3 binary to 3-digit BCD converter; W cycles per conversion.
module bin2bcd_seq
  import fifo_disp_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         busy,
  output logic         done,
  output bcd3_t        bcd
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  sh_q;
  bcd3_t         acc_q, adj;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q;

  always_comb begin
    adj = acc_q;
    for (int i = 0; i < 3; i++) begin
      if (acc_q[i] >= 4'd5) adj[i] = acc_q[i] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        sh_q   <= bin;
        acc_q  <= '0;
        cnt_q  <= CW'(W);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        acc_q <= (adj << 1) | {11'd0, sh_q[W-1]};
        sh_q  <= sh_q << 1;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = acc_q;

endmodule

// File: rtl/fifo_disp_feeder.sv
// Snapshots async-FIFO status into two BCD display pages and drives the page select.
// Optional: define FIFO_DISP_AUTO_PAGE_EN for a periodic automatic page flip.
module fifo_disp_feeder
  import fifo_disp_pkg::*;
#(
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned DEB_CYCLES     = 500_000,
  parameter int unsigned REFRESH_CYCLES = 5_000_000,
  parameter int unsigned PAGE_TICKS     = 100_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            key_n,
  input  logic [7:0]      wr_data,
  input  logic [7:0]      rd_data,
  input  logic [ADDR_W:0] wr_ptr,
  input  logic [ADDR_W:0] rd_ptr,
  input  logic            full,
  input  logic            empty,
  output logic            select,
  output nibble_t         HEX5a, HEX4a, HEX3a, HEX2a, HEX1a, HEX0a,
  output nibble_t         HEX5b, HEX4b, HEX3b, HEX2b, HEX1b, HEX0b
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned RW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  // Key synchroniser and debounce; accepted level idles high.
  logic          key_s1_q, key_s2_q, key_db_q, key_fall, sel_toggle, select_q;
  logic [DW-1:0] deb_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_s1_q  <= 1'b1;
      key_s2_q  <= 1'b1;
      key_db_q  <= 1'b1;
      deb_cnt_q <= '0;
    end else begin
      key_s1_q <= key_n;
      key_s2_q <= key_s1_q;
      if (key_s2_q == key_db_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
        key_db_q  <= key_s2_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end
  end

  assign key_fall = key_db_q && !key_s2_q && (deb_cnt_q == DW'(DEB_CYCLES - 1));

`ifdef FIFO_DISP_AUTO_PAGE_EN
  localparam int unsigned PGW = $clog2(PAGE_TICKS + 1);
  logic [PGW-1:0] page_cnt_q;
  logic           page_wrap;

  assign page_wrap = (page_cnt_q == PGW'(PAGE_TICKS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)                     page_cnt_q <= '0;
    else if (key_fall || page_wrap) page_cnt_q <= '0;
    else                            page_cnt_q <= page_cnt_q + 1'b1;
  end

  // Coincident key and auto events collapse into one toggle.
  assign sel_toggle = key_fall | page_wrap;
`else
  assign sel_toggle = key_fall;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) select_q <= 1'b0;
    else        select_q <= select_q ^ sel_toggle;
  end

  assign select = select_q;

  logic [RW-1:0] ref_cnt_q;
  logic          tick;

  assign tick = (ref_cnt_q == RW'(REFRESH_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)    ref_cnt_q <= '0;
    else if (tick) ref_cnt_q <= '0;
    else           ref_cnt_q <= ref_cnt_q + 1'b1;
  end

  // Pointer difference above DEPTH can only come from corrupt pointers; clamp it.
  logic [ADDR_W:0] diff, occ, free;
  assign diff = wr_ptr - rd_ptr;
  assign occ  = (diff > DEPTH) ? DEPTH : diff;
  assign free = DEPTH - occ;

  fsm_t    state_q, state_d;
  logic    start, load, conv_done;
  logic    occ_busy, occ_done, free_busy, free_done;
  bcd3_t   occ_bcd, free_bcd;
  logic [7:0] wr_data_q, rd_data_q;
  nibble_t flags_q;

  assign start     = (state_q == IDLE) && tick;
  assign conv_done = occ_done && free_done && !occ_busy && !free_busy;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: if (tick) state_d = CONV;
      CONV: if (conv_done) state_d = LOAD;
      LOAD: begin
        load    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_data_q <= '0;
      rd_data_q <= '0;
      flags_q   <= '0;
    end else if (start) begin
      wr_data_q <= wr_data;
      rd_data_q <= rd_data;
      flags_q   <= flag_nib(full, empty);
    end
  end

  bin2bcd_seq #(.W(ADDR_W + 1)) u_occ_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (occ),
    .busy  (occ_busy),
    .done  (occ_done),
    .bcd   (occ_bcd)
  );

  bin2bcd_seq #(.W(ADDR_W + 1)) u_free_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (free),
    .busy  (free_busy),
    .done  (free_done),
    .bcd   (free_bcd)
  );

  // Both pages update in the same cycle so the display never shows a mix.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {HEX5a, HEX4a, HEX3a, HEX2a, HEX1a, HEX0a} <= '0;
      {HEX5b, HEX4b, HEX3b, HEX2b, HEX1b, HEX0b} <= '0;
    end else if (load) begin
      {HEX5a, HEX4a} <= wr_data_q;
      {HEX5b, HEX4b} <= rd_data_q;
      HEX3a          <= flags_q;
      HEX3b          <= flags_q;
      {HEX2a, HEX1a, HEX0a} <= occ_bcd;
      {HEX2b, HEX1b, HEX0b} <= free_bcd;
    end
  end

endmodule

// File: tb/tb_fifo_disp_feeder.sv
// Self-checking bench for fifo_disp_feeder (ADDR_W=4); auto-page checks under FIFO_DISP_AUTO_PAGE_EN.
module tb_fifo_disp_feeder;

  logic       clk = 1'b0;
  logic       rst_n, key_n, full, empty;
  logic [7:0] wr_data, rd_data;
  logic [4:0] wr_ptr, rd_ptr;
  logic       select;
  logic [3:0] HEX5a, HEX4a, HEX3a, HEX2a, HEX1a, HEX0a;
  logic [3:0] HEX5b, HEX4b, HEX3b, HEX2b, HEX1b, HEX0b;
  logic [23:0] page_a, page_b;

  always #5 clk = ~clk;

  fifo_disp_feeder #(
    .ADDR_W         (4),
    .DEB_CYCLES     (4),
    .REFRESH_CYCLES (16),
    .PAGE_TICKS     (64)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key_n),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr),
    .full    (full),
    .empty   (empty),
    .select  (select),
    .HEX5a   (HEX5a),
    .HEX4a   (HEX4a),
    .HEX3a   (HEX3a),
    .HEX2a   (HEX2a),
    .HEX1a   (HEX1a),
    .HEX0a   (HEX0a),
    .HEX5b   (HEX5b),
    .HEX4b   (HEX4b),
    .HEX3b   (HEX3b),
    .HEX2b   (HEX2b),
    .HEX1b   (HEX1b),
    .HEX0b   (HEX0b)
  );

  assign page_a = {HEX5a, HEX4a, HEX3a, HEX2a, HEX1a, HEX0a};
  assign page_b = {HEX5b, HEX4b, HEX3b, HEX2b, HEX1b, HEX0b};

  typedef struct {
    logic [4:0]  wp, rp;
    logic [7:0]  wd, rd;
    logic        fl, em;
    logic [23:0] exp_a, exp_b;
  } vec_t;

  typedef struct packed {
    logic [23:0] a;
    logic [23:0] b;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    wr_ptr  = v.wp;
    rd_ptr  = v.rp;
    wr_data = v.wd;
    rd_data = v.rd;
    full    = v.fl;
    empty   = v.em;
  endtask

  // Holds reset for n edges; returns 1 ns after the last reset edge with rst_n released.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    step(n);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{5'd13, 5'd2,  8'hA7, 8'h3C, 1'b0, 1'b0, 24'hA70011, 24'h3C0005};
    vecs[1] = '{5'd3,  5'd19, 8'h55, 8'h66, 1'b1, 1'b0, 24'h552016, 24'h662000};
    vecs[2] = '{5'd30, 5'd0,  8'h00, 8'hFF, 1'b0, 1'b0, 24'h000016, 24'hFF0000};
    vecs[3] = '{5'd7,  5'd7,  8'h12, 8'h34, 1'b0, 1'b1, 24'h121000, 24'h341016};
    vecs[4] = '{5'd0,  5'd31, 8'hFE, 8'h01, 1'b0, 1'b0, 24'hFE0001, 24'h010015};
    vecs[5] = '{5'd17, 5'd8,  8'h9B, 8'hC4, 1'b1, 1'b1, 24'h9B3009, 24'hC43007};

    key_n = 1'b1;
    drive(vecs[0]);
    @(negedge clk);
    do_reset(3);
    check("reset_page_a", 32'(page_a), 32'h0);
    check("reset_page_b", 32'(page_b), 32'h0);
    check("reset_select", 32'(select), 32'h0);

    // Two refresh periods guarantee a full snapshot/convert/load with the new inputs.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i]);
      sb.push_back('{a: vecs[i].exp_a, b: vecs[i].exp_b});
      step(32);
      e = sb.pop_front();
      check($sformatf("vec%0d_page_a", i), 32'(page_a), 32'(e.a));
      check($sformatf("vec%0d_page_b", i), 32'(page_b), 32'(e.b));
    end

`ifndef FIFO_DISP_AUTO_PAGE_EN
    key_n = 1'b0;
    step(3);
    key_n = 1'b1;
    step(10);
    check("key_glitch_select", 32'(select), 32'h0);
    key_n = 1'b0;
    step(10);
    check("key_press_select", 32'(select), 32'h1);
    step(20);
    check("key_hold_select", 32'(select), 32'h1);
    key_n = 1'b1;
    step(10);
    check("key_release_select", 32'(select), 32'h1);
`endif

    // Exact latency after reset release: tick at +16, pages loaded at +23.
    drive(vecs[0]);
    sb.push_back('{a: vecs[0].exp_a, b: vecs[0].exp_b});
    do_reset(2);
    step(22);
    check("latency_before_page_a", 32'(page_a), 32'h0);
    step(1);
    e = sb.pop_front();
    check("latency_at_page_a", 32'(page_a), 32'(e.a));
    check("latency_at_page_b", 32'(page_b), 32'(e.b));

    // Next tick at +32; reset lands two cycles later, mid-conversion.
    drive(vecs[5]);
    sb.push_back('{a: vecs[5].exp_a, b: vecs[5].exp_b});
    step(10);
    rst_n = 1'b0;
    step(1);
    check("midconv_reset_page_a", 32'(page_a), 32'h0);
    check("midconv_reset_page_b", 32'(page_b), 32'h0);
    check("midconv_reset_select", 32'(select), 32'h0);
    rst_n = 1'b1;
    step(22);
    check("rerun_before_page_b", 32'(page_b), 32'h0);
    step(1);
    e = sb.pop_front();
    check("rerun_at_page_a", 32'(page_a), 32'(e.a));
    check("rerun_at_page_b", 32'(page_b), 32'(e.b));

`ifdef FIFO_DISP_AUTO_PAGE_EN
    do_reset(2);
    step(63);
    check("auto_before_wrap1", 32'(select), 32'h0);
    step(1);
    check("auto_wrap1", 32'(select), 32'h1);
    step(63);
    check("auto_before_wrap2", 32'(select), 32'h1);
    step(1);
    check("auto_wrap2", 32'(select), 32'h0);
    // Key driven low here is accepted six edges later, on the third auto wrap.
    step(58);
    key_n = 1'b0;
    step(5);
    check("auto_key_before", 32'(select), 32'h0);
    step(1);
    check("auto_key_coincide", 32'(select), 32'h1);
    step(63);
    check("auto_after_restart_hold", 32'(select), 32'h1);
    step(1);
    check("auto_after_restart_wrap", 32'(select), 32'h0);
    key_n = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
